// File: rtl/issue_collapse_queue_mw.sv
// Collapsing age-ordered multi-issue queue with CDB wakeup and EBR squash.
// Optional: ISSUE_QUEUE_ENQ_WAKEUP_EN wakes wdata operands in the enqueue cycle.
package issue_pkg;
  localparam int EBR_MASK_SIZE = 4;
  localparam int CDB_WIDTH = 2;
  localparam int PRF_W = 6;

  typedef struct packed {
    logic [PRF_W-1:0] prd_s;
  } cdb_t;

  typedef struct packed {
    logic [EBR_MASK_SIZE-1:0] ebr_mask;
    logic [PRF_W-1:0] prs1_s;
    logic prs1_ready;
    logic [PRF_W-1:0] prs2_s;
    logic prs2_ready;
    logic [PRF_W-1:0] prd_s;
    logic [7:0] uop;
  } rstation_t;

  typedef struct packed {
    logic [EBR_MASK_SIZE-1:0] ebr_mask;
    logic [PRF_W-1:0] prs1_s;
    logic [PRF_W-1:0] prs2_s;
    logic [PRF_W-1:0] prd_s;
    logic [7:0] uop;
  } rstation_issue_t;

  typedef struct packed {
    logic inv;
    logic [EBR_MASK_SIZE-1:0] mask;
  } ebr_res_t;

  function automatic ebr_res_t ebr_resolve(
    input logic [EBR_MASK_SIZE-1:0] mask,
    input logic [EBR_MASK_SIZE-1:0] id,
    input logic done,
    input logic misp
  );
    ebr_res_t r;
    r.inv = done & misp & (|(mask & id));
    r.mask = done ? (mask & ~id) : mask;
    return r;
  endfunction
endpackage

module issue_collapse_queue_mw
  import issue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int ISSUE_WIDTH = 2,
  localparam int CW = $clog2(QUEUE_DEPTH+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enqueue,
  input  rstation_t wdata,
  output logic ready_in,
  output logic [CW-1:0] count,
  output logic [ISSUE_WIDTH-1:0] issue_valid,
  output rstation_issue_t issue_data [ISSUE_WIDTH],
  input  logic [ISSUE_WIDTH-1:0] issue_ack,
  input  cdb_t cdb_out [CDB_WIDTH],
  input  logic [CDB_WIDTH-1:0] cdb_bc,
  input  logic late_flush,
  input  logic bra_done,
  input  logic bra_mispredict,
  input  logic [EBR_MASK_SIZE-1:0] bra_id
);
  localparam int D = QUEUE_DEPTH;

  logic [D-1:0] r_valid;
  rstation_t r_ent [D];
  logic [CW-1:0] r_count;

  ebr_res_t w_res [D];
  rstation_t w_upd [D];
  logic [D-1:0] w_inv;
  logic [D-1:0] w_rdy;
  logic [D-1:0] w_take;
  ebr_res_t w_in_res;
  rstation_t w_in;
  logic w_enq;
  rstation_t w_n_ent [D];
  logic [D-1:0] w_n_valid;
  logic [CW-1:0] w_ncnt;

  assign count = r_count;
  assign ready_in = (r_count < CW'(D));

  // Per-slot branch resolution, issue readiness and CDB wakeup.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      w_res[i] = ebr_resolve(r_ent[i].ebr_mask, bra_id,
                             bra_done, bra_mispredict);
      w_inv[i] = r_valid[i] & w_res[i].inv;
      w_rdy[i] = r_valid[i] & r_ent[i].prs1_ready
               & r_ent[i].prs2_ready & ~w_res[i].inv;
      w_upd[i] = r_ent[i];
      w_upd[i].ebr_mask = w_res[i].mask;
      for (int j = 0; j < CDB_WIDTH; j++) begin
        if (cdb_bc[j] && cdb_out[j].prd_s == r_ent[i].prs1_s)
          w_upd[i].prs1_ready = 1'b1;
        if (cdb_bc[j] && cdb_out[j].prd_s == r_ent[i].prs2_s)
          w_upd[i].prs2_ready = 1'b1;
      end
    end
  end

  // Incoming entry: resolve its mask, drop it if squashed.
  always_comb begin
    w_in_res = ebr_resolve(wdata.ebr_mask, bra_id,
                           bra_done, bra_mispredict);
    w_in = wdata;
    w_in.ebr_mask = w_in_res.mask;
`ifdef ISSUE_QUEUE_ENQ_WAKEUP_EN
    for (int j = 0; j < CDB_WIDTH; j++) begin
      if (cdb_bc[j] && cdb_out[j].prd_s == wdata.prs1_s)
        w_in.prs1_ready = 1'b1;
      if (cdb_bc[j] && cdb_out[j].prd_s == wdata.prs2_s)
        w_in.prs2_ready = 1'b1;
    end
`endif
    w_enq = enqueue & ready_in & ~w_in_res.inv;
  end

  // Oldest-first port selection; port k gets the k-th ready slot.
  always_comb begin
    logic [5:0] acc;
    acc = '0;
    w_take = '0;
    issue_valid = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++)
      issue_data[k] = '0;
    for (int i = 0; i < D; i++) begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (w_rdy[i] && int'(acc) == k) begin
          issue_valid[k] = 1'b1;
          issue_data[k].ebr_mask = w_res[i].mask;
          issue_data[k].prs1_s = r_ent[i].prs1_s;
          issue_data[k].prs2_s = r_ent[i].prs2_s;
          issue_data[k].prd_s = r_ent[i].prd_s;
          issue_data[k].uop = r_ent[i].uop;
          w_take[i] = issue_ack[k];
        end
      end
      if (w_rdy[i])
        acc = acc + 6'd1;
    end
  end

  // Compaction: survivors in age order, then the accepted enqueue.
  always_comb begin
    logic [CW-1:0] dst;
    dst = '0;
    w_n_ent = r_ent;
    for (int i = 0; i < D; i++) begin
      if (r_valid[i] && !w_inv[i] && !w_take[i]) begin
        for (int o = 0; o < D; o++)
          if (int'(dst) == o)
            w_n_ent[o] = w_upd[i];
        dst = dst + CW'(1);
      end
    end
    w_ncnt = dst;
    if (w_enq) begin
      for (int o = 0; o < D; o++)
        if (int'(dst) == o)
          w_n_ent[o] = w_in;
      w_ncnt = dst + CW'(1);
    end
    for (int i = 0; i < D; i++)
      w_n_valid[i] = (int'(w_ncnt) > i);
  end

  // State update; flush wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      r_ent <= '{default: '0};
    end else if (late_flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_n_valid;
      r_count <= w_ncnt;
      r_ent <= w_n_ent;
    end
  end
endmodule

// File: doc/issue_collapse_queue_mw.md
# issue_collapse_queue_mw

Multi-issue, fully collapsing, age-ordered issue queue that sits between a reservation-station dispatch port and up to ISSUE_WIDTH execution-unit issue ports. Each cycle it accepts at most one renamed instruction, wakes operands from every CDB lane, applies EBR branch resolution and squash, and presents the oldest ready entries on ISSUE_WIDTH ports. Entries removed by issue or squash are compacted out in a single cycle, so occupancy is always a contiguous prefix of the slots.

## Interface
- QUEUE_DEPTH, 8, number of entry slots; legal range 2..32
- ISSUE_WIDTH, 2, number of issue ports; legal range 1..4, at most QUEUE_DEPTH
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- enqueue  in  1  write wdata this cycle; legal only when ready_in=1
- wdata  in  rstation_t  incoming entry
- ready_in  out  1  queue can accept an enqueue this cycle
- count  out  $clog2(QUEUE_DEPTH+1)  number of valid entries (registered)
- issue_valid  out  [ISSUE_WIDTH]  port k carries a ready entry
- issue_data  out  rstation_issue_t [ISSUE_WIDTH]  entry presented on port k
- issue_ack  in  [ISSUE_WIDTH]  consumer takes port k's entry this cycle; ignored when issue_valid[k]=0
- cdb_out  in  cdb_t [CDB_WIDTH]  broadcast tags (prd_s)
- cdb_bc  in  [CDB_WIDTH]  lane j broadcasts this cycle
- late_flush  in  1  synchronous full flush from ROB
- bra_done, bra_mispredict  in  1 each  EBR resolution event
- bra_id  in  EBR_MASK_SIZE  resolving branch id

## Operation
- Slot 0 holds the oldest entry; valid entries always occupy slots 0..count-1.
- Ready condition for slot i: valid and prs1_ready and prs2_ready and not (bra_done and EBR-invalid for slot i). Ready bits are taken from registered state only; a same-cycle CDB hit does not make an entry issuable.
- Selection: port 0 gets the lowest-index ready slot, port 1 the next, and so on. Unused ports drive issue_valid=0, and issue_data is don't-care.
- issue_data fields are copied from the slot. When bra_done=1, ebr_mask is replaced by the resolved mask.
- An entry leaves when its port is acked, or when it is squashed (bra_done and mispredict-invalid, via ebr_resolve per slot). Ready but unacked entries stay in place.
- Per slot every cycle: ebr_mask is updated by the resolved mask when bra_done=1. prs1_ready/prs2_ready are set when any cdb_bc[j] lane's prd_s matches prs1_s/prs2_s.
- Compaction: next state = surviving entries in original order, followed by the enqueued entry if accepted. Count is updated accordingly.
- Incoming wdata passes through its own ebr_resolve. If bra_done=1 and it is invalid, it is dropped and count does not increment. Otherwise its mask is resolved before it is written.
- ready_in = (count < QUEUE_DEPTH), computed from registered count only; no combinational path from issue_ack.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits 0, count=0. Outputs: ready_in=1, issue_valid=0.
- late_flush=1: at the next edge all valid bits are cleared and count=0. Flush has priority over enqueue, issue and wakeup.
- Enqueue at edge N: the entry is visible at edge N+1 and can issue in cycle N+1 at the earliest if both operands are ready.
- CDB wakeup in cycle N makes the entry issuable in cycle N+1.
- Acks in cycle N remove entries at edge N+1. count reflects removals and the enqueue together.
- When full, ready_in=0 even if acks are in flight. A freed slot is reported one cycle later.
- Enqueue while issue_ack or a squash occur in the same cycle: all three apply, and the new entry is placed after the survivors.
- A CDB broadcast matching a squashed entry has no effect.

## Configuration
- ISSUE_QUEUE_ENQ_WAKEUP_EN defined: wdata operand ready bits are also OR-ed with same-cycle CDB matches before the write. A tag broadcast in the enqueue cycle is therefore not lost.
- Not defined: wdata ready bits are written as supplied. Upstream guarantees that a same-cycle broadcast is already reflected in wdata.

## Test plan
- Reset mid-operation: fill 5 entries, pulse rst_n=0 asynchronously -> count=0, ready_in=1, issue_valid=0 immediately, before the next edge.
- Oldest-first dual issue: enqueue A, B, C all ready; ack both ports -> port0=A, port1=B; next cycle port0=C, count=1.
- Collapse: DEPTH=8 full, slots 2 and 5 acked -> next cycle count=6 in order 0,1,3,4,6,7; ready_in=1.
- Squash plus enqueue: bra_done=1, bra_mispredict=1 invalidating slots 1 and 3 of 4, with a valid enqueue the same cycle -> count=3, survivors in order, new entry in slot 2.
- Wakeup: entry with prs1 not ready, CDB lane 1 broadcasts a matching prd_s in cycle N -> issue_valid[0]=1 in cycle N+1, not in cycle N.
- Enqueue-cycle wakeup: enqueue with prs2_ready=0 while the CDB broadcasts prs2_s -> with the macro, issuable next cycle; without the macro, the entry stays not-ready.
